// File: rtl/dual_rail_pkg.sv
// Shared definitions for the dual-rail receive path: rail indices, encoding
// selectors, FSM states and the per-bit code decode helper.
package dual_rail_pkg;

    localparam int unsigned RAIL_NUM = 2;
    localparam int unsigned RAIL_T   = 1;
    localparam int unsigned RAIL_F   = 0;

    // Encoding selector: two ASCII characters packed into 16 bits.
    typedef logic [15:0] enc_t;
    localparam enc_t ENC_TP = "TP";
    localparam enc_t ENC_FP = "FP";

    typedef enum logic {
        COLLECT = 1'b0,
        RTZ     = 1'b1
    } state_t;

    // present: at least one rail active (bit may be captured)
    // clash:   both rails active (protocol violation)
    // value:   true-rail level, used as the decoded bit
    typedef struct packed {
        logic present;
        logic clash;
        logic value;
    } bit_status_t;

    // Decode one bit's rail pair. The caller supplies either the transition
    // vector (two-phase) or the raw rail levels (four-phase).
    function automatic bit_status_t bit_decode(input logic [RAIL_NUM-1:0] code);
        bit_status_t r;
        r.present = code[RAIL_T] | code[RAIL_F];
        r.clash   = code[RAIL_T] & code[RAIL_F];
        r.value   = code[RAIL_T];
        return r;
    endfunction

endpackage

// File: rtl/dual_rail_sync.sv
// Two-flop synchronizer for the asynchronous dual-rail link, reset to zero.
module dual_rail_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two register stages between the link and the receiver logic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dual_rail_receiver.sv
// Receive end of a dual-rail link: synchronizes the rails, detects a complete
// code word (two-phase transition or four-phase RTZ), decodes it onto a
// valid/ready output and drives the link acknowledge.
module dual_rail_receiver
    import dual_rail_pkg::*;
#(
    parameter enc_t        ENC   = ENC_TP,
    parameter int unsigned WIDTH = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [WIDTH-1:0][RAIL_NUM-1:0]     in,
    output logic                               ack,
    output logic [WIDTH-1:0]                   data,
    output logic                               valid,
    input  logic                               ready,
    output logic                               err
);

    if ((ENC != ENC_TP) && (ENC != ENC_FP)) begin : g_bad_enc
        $error("dual_rail_receiver: ENC must be \"TP\" or \"FP\"");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("dual_rail_receiver: WIDTH must be at least 1");
    end

    localparam bit          IS_TP = (ENC == ENC_TP);
    localparam int unsigned NBITS = WIDTH * RAIL_NUM;

    logic [NBITS-1:0]              in_flat;
    logic [NBITS-1:0]              s_flat;
    logic [WIDTH-1:0][RAIL_NUM-1:0] s;
    logic [WIDTH-1:0][RAIL_NUM-1:0] s_prev;
    logic [WIDTH-1:0][RAIL_NUM-1:0] ref_q;
    logic [WIDTH-1:0][RAIL_NUM-1:0] ref_n;
    logic [WIDTH-1:0][RAIL_NUM-1:0] code;

    state_t           state, state_n;
    logic             ack_n, valid_n, err_n;
    logic [WIDTH-1:0] data_n;

    bit_status_t      st;
    logic             word_done;
    logic             any_clash;
    logic             all_zero;
    logic             rising;
    logic [WIDTH-1:0] word_val;

    assign in_flat = in;
    assign s       = s_flat;

    dual_rail_sync #(
        .WIDTH (NBITS)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (in_flat),
        .q   (s_flat)
    );

    // Word completion, clash detection and decode from the synchronized rails.
    // A clashing bit still counts as present so the word is captured using its
    // true rail; the clash itself is reported through err.
    always_comb begin
        st        = '0;
        word_done = 1'b1;
        any_clash = 1'b0;
        word_val  = '0;
        code      = IS_TP ? (s ^ ref_q) : s;
        all_zero  = (s == '0);
        rising    = |(s & ~s_prev);
        for (int unsigned b = 0; b < WIDTH; b++) begin
            st          = bit_decode(code[b]);
            word_done   = word_done & st.present;
            any_clash   = any_clash | st.clash;
            word_val[b] = st.value;
        end
    end

    // Next-state and output logic: capture into a free (or freeing) slot,
    // acknowledge, and in four-phase mode wait for the spacer.
    always_comb begin
        state_n = state;
        ack_n   = ack;
        data_n  = data;
        valid_n = valid;
        err_n   = err;
        ref_n   = ref_q;

        if (valid && ready) begin
            valid_n = 1'b0;
        end

        case (state)
            COLLECT: begin
                if (any_clash) begin
                    err_n = 1'b1;
                end
                if (word_done && (!valid || ready)) begin
                    data_n  = word_val;
                    valid_n = 1'b1;
                    if (IS_TP) begin
                        ref_n = s;
                        ack_n = ~ack;
                    end else begin
                        ack_n   = 1'b1;
                        state_n = RTZ;
                    end
                end
            end
            RTZ: begin
                if (rising) begin
                    err_n = 1'b1;
                end
                if (all_zero) begin
                    ack_n   = 1'b0;
                    state_n = COLLECT;
                end
            end
            default: state_n = COLLECT;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= COLLECT;
            ack    <= 1'b0;
            data   <= '0;
            valid  <= 1'b0;
            err    <= 1'b0;
            ref_q  <= '0;
            s_prev <= '0;
        end else begin
            state  <= state_n;
            ack    <= ack_n;
            data   <= data_n;
            valid  <= valid_n;
            err    <= err_n;
            ref_q  <= ref_n;
            s_prev <= s;
        end
    end

endmodule
